// File: rtl/poly_tone_pkg.sv
// Shared constants and helpers for the polyphonic tone bank.
// Holds command field positions, a ceil-log2 helper and the tone amplitude
// function. Parameter-dependent types (env_t etc.) live in the modules.
package poly_tone_pkg;

  // Voice index field inside the 32-bit host command word.
  localparam int unsigned CMD_VOICE_MSB = 31;
  localparam int unsigned CMD_VOICE_LSB = 28;

  // Ceil(log2(n)); clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    longint unsigned v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Square-wave amplitude magnitude for a signed amp_w-bit oscillator.
  function automatic longint unsigned tone_amp(input int unsigned amp_w);
    return (64'd1 << (amp_w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice with a linear attack/release envelope.
// Holds period, gate, phase and envelope level; outputs the voice's scaled
// contribution to the mix and its activity flag.
module tone_voice #(
  parameter int unsigned PERIOD_W     = 23,
  parameter int unsigned AMP_W        = 24,
  parameter int unsigned ENV_W        = 16,
  parameter int unsigned ATTACK_STEP  = 64,
  parameter int unsigned RELEASE_STEP = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       load,
  input  logic        [PERIOD_W-1:0] load_period,
  output logic signed [AMP_W-1:0]    level,
  output logic                       active
);
  import poly_tone_pkg::*;

  typedef logic [ENV_W-1:0]    env_t;
  typedef logic [PERIOD_W-1:0] period_t;

  localparam int unsigned ENV_W1 = ENV_W + 1;
  localparam int unsigned PROD_W = AMP_W + ENV_W + 1;
  localparam logic signed [AMP_W-1:0] TONE_HI = AMP_W'(tone_amp(AMP_W));
  localparam logic signed [AMP_W-1:0] TONE_LO = -TONE_HI;
  localparam env_t ENV_MAX = '1;

  period_t period_q, period_d;
  period_t phase_q, phase_d;
  logic    gate_q, gate_d;
  env_t    env_q, env_d;

  logic signed [AMP_W-1:0] tone;
  logic        [ENV_W:0]   env_up;

  // One oscillator step: wraps at period-1, parks at 0 for periods 0 and 1.
  // The >= wrap keeps the phase bounded after a period shrinks.
  function automatic period_t phase_step(input period_t ph, input period_t p);
    if (p <= period_t'(1)) return '0;
    if (ph >= p - period_t'(1)) return '0;
    return ph + period_t'(1);
  endfunction

  // Oscillator advance plus note-on/note-off handling for this voice.
  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    period_d = period_q;
    gate_d   = gate_q;
    phase_d  = phase_step(phase_q, period_q);
    if (load) begin
      if (load_period != '0) begin
        gate_d   = 1'b1;
        period_d = load_period;
        if (phase_q >= load_period) phase_d = '0;
      end else begin
        gate_d = 1'b0;
      end
    end
  end

  // Square wave: positive for the first half of the period, silent when idle.
  always_comb begin
    if (period_q <= period_t'(1))            tone = '0;
    else if (phase_q < (period_q >> 1))      tone = TONE_HI;
    else                                     tone = TONE_LO;
  end

  // Envelope update on the sample tick, driven by the gate held before any
  // command in this cycle.
  always_comb begin
    env_up = {1'b0, env_q} + ENV_W1'(ATTACK_STEP);
    env_d  = env_q;
    if (tick) begin
      if (gate_q)
        env_d = env_up[ENV_W] ? ENV_MAX : env_up[ENV_W-1:0];
      else if ({1'b0, env_q} <= ENV_W1'(RELEASE_STEP))
        env_d = '0;
      else
        env_d = env_q - ENV_W'(RELEASE_STEP);
    end
  end

  // Voice state registers.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      phase_q  <= '0;
      gate_q   <= 1'b0;
      env_q    <= '0;
    end else begin
      period_q <= period_d;
      phase_q  <= phase_d;
      gate_q   <= gate_d;
      env_q    <= env_d;
    end
  end

  // Scaled contribution: (tone * env) >>> ENV_W, operands widened first so the
  // full product is kept before the arithmetic shift.
  assign level  = AMP_W'((PROD_W'(tone) * PROD_W'($signed({1'b0, env_q}))) >>> ENV_W);
  assign active = gate_q | (env_q != '0);

endmodule

// File: rtl/poly_tone_bank.sv
// Polyphonic square-wave tone bank: NUM_VOICES voices with linear
// attack/release envelopes, mixed into one signed sample every SAMPLE_DIV clks.
// Build option: define POLY_TONE_SATURATE_EN to clamp the mix to OUT_W bits;
// otherwise the mix wraps (low OUT_W bits of the wide sum).
module poly_tone_bank #(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned PERIOD_W     = 23,
  parameter int unsigned AMP_W        = 24,
  parameter int unsigned ENV_W        = 16,
  parameter int unsigned OUT_W        = 24,
  parameter int unsigned ATTACK_STEP  = 64,
  parameter int unsigned RELEASE_STEP = 16,
  parameter int unsigned SAMPLE_DIV   = 2083
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic        [31:0]           cmd_data,
  output logic signed [OUT_W-1:0]      sample,
  output logic                         sample_valid,
  output logic        [NUM_VOICES-1:0] voice_active,
  output logic                         cmd_err
);
  import poly_tone_pkg::*;

  localparam int unsigned SUM_W = OUT_W + clog2(NUM_VOICES);
  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? clog2(SAMPLE_DIV) : 1;

  logic [3:0]          cmd_voice;
  logic [PERIOD_W-1:0] cmd_period;
  logic                cmd_accept;
  logic                cmd_in_range;
  logic                tick;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    cmd_err_q, cmd_err_d;

  logic signed [AMP_W-1:0] level [NUM_VOICES];
  logic signed [SUM_W-1:0] sum;
  logic signed [OUT_W-1:0] narrow;

  // Command decode: ready whenever out of reset.
  assign cmd_voice    = cmd_data[CMD_VOICE_MSB:CMD_VOICE_LSB];
  assign cmd_period   = cmd_data[PERIOD_W-1:0];
  assign cmd_ready    = ~rst;
  assign cmd_accept   = cmd_valid & cmd_ready;
  assign cmd_in_range = 32'(cmd_voice) < NUM_VOICES;
  assign tick         = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  if (PERIOD_W < CMD_VOICE_LSB) begin : g_unused_cmd
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_data[CMD_VOICE_LSB-1:PERIOD_W];
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    tone_voice #(
      .PERIOD_W    (PERIOD_W),
      .AMP_W       (AMP_W),
      .ENV_W       (ENV_W),
      .ATTACK_STEP (ATTACK_STEP),
      .RELEASE_STEP(RELEASE_STEP)
    ) u_voice (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .load       (cmd_accept && (cmd_voice == 4'(i))),
      .load_period(cmd_period),
      .level      (level[i]),
      .active     (voice_active[i])
    );
  end

  // Mix all voices in a widened accumulator so the sum itself never overflows.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + SUM_W'(level[i]);
  end

`ifdef POLY_TONE_SATURATE_EN
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp the wide sum into the signed OUT_W range.
  always_comb begin
    if (sum > SUM_MAX)      narrow = SUM_MAX[OUT_W-1:0];
    else if (sum < SUM_MIN) narrow = SUM_MIN[OUT_W-1:0];
    else                    narrow = sum[OUT_W-1:0];
  end
`else
  // Two's-complement wrap: keep only the low OUT_W bits of the sum.
  always_comb narrow = sum[OUT_W-1:0];

  if (SUM_W > OUT_W) begin : g_unused_sum
    logic unused_sum_msbs;
    assign unused_sum_msbs = ^sum[SUM_W-1:OUT_W];
  end
`endif

  // Sample tick divider, output sample capture and sticky bad-index flag.
  always_comb begin
    cnt_d          = tick ? '0 : cnt_q + CNT_W'(1);
    sample_d       = tick ? narrow : sample_q;
    sample_valid_d = tick;
    cmd_err_d      = cmd_err_q | (cmd_accept & ~cmd_in_range);
  end

  // Top-level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      cmd_err_q      <= cmd_err_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_poly_tone_bank.sv
// Directed bench for poly_tone_bank with a short sample divider and large
// envelope steps so the attack/release ramps complete in a few ticks.
// Expected mix values come from A = 2^23-1 scaled by env/65536 (floored).
module tb_poly_tone_bank;

  localparam int unsigned NV    = 4;
  localparam int unsigned OUT_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [31:0]       cmd_data = '0;
  logic [OUT_W-1:0]  sample;
  logic              sample_valid;
  logic [NV-1:0]     voice_active;
  logic              cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  poly_tone_bank #(
    .NUM_VOICES  (NV),
    .PERIOD_W    (23),
    .AMP_W       (24),
    .ENV_W       (16),
    .OUT_W       (OUT_W),
    .ATTACK_STEP (16384),
    .RELEASE_STEP(32768),
    .SAMPLE_DIV  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .sample      (sample),
    .sample_valid(sample_valid),
    .voice_active(voice_active),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [31:0] cd;
    logic        ev;
    logic [23:0] es;
    logic [3:0]  ea;
    logic        ee;
  } vec_t;

  vec_t        vecs [36];
  logic [23:0] samp [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge, return at the next negedge.
  task automatic step(input logic v, input logic [31:0] d);
    cmd_valid = v;
    cmd_data  = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc++;
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) step(1'b0, 32'h0);
  endtask

  // Hold reset for 3 clocks, check the reset state, release at a negedge.
  task automatic hold_reset(input string tag);
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, " rst sample"},       32'(sample), 32'h0);
    check({tag, " rst sample_valid"}, 32'(sample_valid), 32'h0);
    check({tag, " rst cmd_ready"},    32'(cmd_ready), 32'h0);
    check({tag, " rst voice_active"}, 32'(voice_active), 32'h0);
    check({tag, " rst cmd_err"},      32'(cmd_err), 32'h0);
    rst = 1'b0;
    #1;
    check({tag, " cmd_ready after rst"}, 32'(cmd_ready), 32'h1);
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Samples seen on successive ticks of the single-voice run.
    samp = '{24'h000000, 24'hE00000, 24'h3FFFFF, 24'hA00000, 24'h7FFF7F,
             24'h800080, 24'h7FFF7F, 24'hC00080, 24'h000000};
    for (int r = 0; r < 36; r++) begin
      vecs[r].cv = (r == 0) || (r == 1) || (r == 24);
      vecs[r].cd = (r == 0) ? 32'h0000_0008 : (r == 1) ? 32'h5000_0010 : 32'h0000_0000;
      vecs[r].ev = (r % 4) == 3;
      vecs[r].es = (r < 3) ? 24'h0 : samp[(r - 3) / 4];
      vecs[r].ea = (r <= 30) ? 4'b0001 : 4'b0000;
      vecs[r].ee = (r >= 1);
    end

    @(negedge clk);
    hold_reset("init");

    // Single voice attack, bad index, release; first pulse after 4 clks.
    for (int r = 0; r < 36; r++) begin
      step(vecs[r].cv, vecs[r].cd);
      check($sformatf("vec%0d sample_valid", r), 32'(sample_valid), 32'(vecs[r].ev));
      check($sformatf("vec%0d sample", r),       32'(sample),       32'(vecs[r].es));
      check($sformatf("vec%0d voice_active", r), 32'(voice_active), 32'(vecs[r].ea));
      check($sformatf("vec%0d cmd_err", r),      32'(cmd_err),      32'(vecs[r].ee));
    end

    // Note-on in a tick cycle: env stays 0 at that tick, rises at the next.
    idle_until(39);
    step(1'b1, 32'h0000_0008);
    check("simul tick39 valid",  32'(sample_valid), 32'h1);
    check("simul tick39 sample", 32'(sample), 32'h0);
    check("simul tick39 active", 32'(voice_active), 32'h1);
    idle_until(43);
    step(1'b0, 32'h0);
    check("simul tick43 sample", 32'(sample), 32'h0);
    step(1'b0, 32'h0);
    check("simul c44 valid low", 32'(sample_valid), 32'h0);
    check("simul c44 sample held", 32'(sample), 32'h0);
    idle_until(47);
    step(1'b0, 32'h0);
    check("simul tick47 sample", 32'(sample), 32'hE00000);
    check("cmd_err still set", 32'(cmd_err), 32'h1);

    // Asynchronous reset mid-operation clears state without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async sample",       32'(sample), 32'h0);
    check("async voice_active", 32'(voice_active), 32'h0);
    check("async cmd_err",      32'(cmd_err), 32'h0);
    check("async cmd_ready",    32'(cmd_ready), 32'h0);
    hold_reset("mid");

    // Four voices loaded 8 clks apart share phase; full env on all four.
    step(1'b1, 32'h0000_0008);
    idle_until(8);
    step(1'b1, 32'h1000_0008);
    idle_until(16);
    step(1'b1, 32'h2000_0008);
    idle_until(24);
    step(1'b1, 32'h3000_0008);
    check("ovf active", 32'(voice_active), 32'hF);
    idle_until(43);
    step(1'b0, 32'h0);
    check("ovf pos valid", 32'(sample_valid), 32'h1);
`ifdef POLY_TONE_SATURATE_EN
    check("ovf pos sample", 32'(sample), 32'h7FFFFF);
`else
    check("ovf pos sample", 32'(sample), 32'hFFFDFC);
`endif
    idle_until(47);
    step(1'b0, 32'h0);
`ifdef POLY_TONE_SATURATE_EN
    check("ovf neg sample", 32'(sample), 32'h800000);
`else
    check("ovf neg sample", 32'(sample), 32'h000200);
`endif
    check("ovf cmd_err clear", 32'(cmd_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_tone_bank.md
Name: poly_tone_bank

Overview:
- Parametrised successor to the single square generator plus envelope chain. Provides NUM_VOICES independent square-wave voices, each with its own linear attack/release envelope.
- Voices are mixed into one saturated signed sample that is delivered once per SAMPLE_DIV clocks.
- Sits between the 32-bit host command stream (write_32 FIFO output) and the codec audio input, in the clk_calc domain.

Parameters:
- NUM_VOICES, 4: voice count, 1..16.
- PERIOD_W, 23: width of the period field, in clk cycles per full wave.
- AMP_W, 24: signed oscillator amplitude width.
- ENV_W, 16: unsigned envelope level width.
- OUT_W, 24: signed mixed output width.
- ATTACK_STEP, 64: envelope increment per sample tick.
- RELEASE_STEP, 16: envelope decrement per sample tick.
- SAMPLE_DIV, 2083: clocks per output sample (100 MHz / 48 kHz).

Ports:
- clk  in  1  clk_calc domain clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_data  in  32  [31:28] voice index; [PERIOD_W-1:0] period (0 = note-off).
- sample  out  OUT_W  signed mixed sample.
- sample_valid  out  1  one-cycle pulse when sample updates.
- voice_active  out  NUM_VOICES  bit i = gate_i || env_i != 0.
- cmd_err  out  1  sticky: command addressed a voice index >= NUM_VOICES.

Behaviour:
- Reset values: all voices have period=0, gate=0, env=0, phase=0. sample=0, sample_valid=0, cmd_err=0, voice_active=0. cmd_ready=0 while rst is high, 1 otherwise.
- Command accept (valid&&ready), index v < NUM_VOICES:
  - period != 0: gate_v=1 and period_v=period. If phase_v >= new period, phase_v resets to 0; otherwise phase continues.
  - period == 0: gate_v=0; period_v is retained.
- Index >= NUM_VOICES: command dropped, cmd_err=1 until rst.
- Oscillator (every clk, per voice, when period_v != 0):
  - phase wraps to 0 at period_v-1.
  - tone = +(2^(AMP_W-1)-1) while phase < period_v>>1, else -(2^(AMP_W-1)-1).
  - period_v == 0 or period_v == 1: tone=0, phase held at 0.
- Tick counter counts 0..SAMPLE_DIV-1; tick is the cycle where count == SAMPLE_DIV-1.
- Envelope (at tick only):
  - gate=1: env = min(env+ATTACK_STEP, 2^ENV_W-1).
  - gate=0: env = max(env-RELEASE_STEP, 0).
  - No sustain or decay stage: holds at max while gated.
- Command and tick in the same cycle: the envelope update uses the pre-command gate. The new gate acts from the next tick.
- Mix at tick:
  - voice_i = (tone_i * env_i) >>> ENV_W, keeping AMP_W signed bits.
  - Sum across voices in OUT_W+clog2(NUM_VOICES) bits; voices use post-tick-update env values only from the next tick.
  - Result is narrowed to OUT_W (see Optional Feature).
- Output latency: sample is registered 1 clk after tick; sample_valid pulses in that same cycle. sample holds between pulses.
- rst asserted mid-operation: all state clears immediately (async); the first sample_valid occurs SAMPLE_DIV+1 clks after deassert.

Optional Feature:
- Macro POLY_TONE_SATURATE_EN.
- Defined: the sum clamps to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Undefined: the sum is truncated to its low OUT_W bits (two's-complement wrap). This saves the comparator logic; host software is then responsible for limiting to NUM_VOICES/... headroom.

Decomposition:
- Package poly_tone_pkg holds:
  - CMD_VOICE_MSB=31 and CMD_VOICE_LSB=28.
  - function clog2.
  - the tone amplitude constant.
  - typedef env_t (logic [ENV_W-1:0]) is parameter-dependent, so it lives in the module; the package holds field positions only.
- Sub-module tone_voice: one instance per voice, generated in a loop. It holds period/gate/phase/env and takes tick and a load strobe. The top level holds the cmd decode, tick counter, mixer and saturation.

Test Plan:
- Reset: rst=1 for 3 clks -> sample=0, sample_valid=0, cmd_ready=0, voice_active=0. After deassert, cmd_ready=1 and the first sample_valid arrives at clk SAMPLE_DIV+1.
- Single voice (SAMPLE_DIV=4, ATTACK_STEP=16384, ENV_W=16): cmd 0x0000_0008 -> voice 0 toggles every 4 clks. env reads 16384, 32768, 49152, 65535 on successive ticks (the last clamps). voice_active=4'b0001.
- Release: after full attack, cmd 0x0000_0000 with RELEASE_STEP=32768 -> env 32767, then 0. voice_active[0] clears at the tick where env reaches 0.
- Overflow: 4 voices at period 8, same phase, full env -> with POLY_TONE_SATURATE_EN, sample=0x7FFFFF on the positive half and 0x800000 on the negative half. Without it, the wrapped low 24 bits appear.
- Bad index: cmd 0x5000_0010 with NUM_VOICES=4 -> cmd_err=1, no voice_active change. cmd_err stays set until rst.
- Simultaneous cmd and tick: note-on in the tick cycle -> env stays 0 at that tick and becomes ATTACK_STEP at the next tick.
